// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared channel state type, default widths and index helper for data_mem_controller
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELEASE} channel_state_t;
  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_NUM_CONSUMERS = 8;
  localparam int DEF_NUM_CHANNELS = 2;
  function automatic int wrap_add(int a, int b, int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/mem_ctrl_channel.sv
// mem_ctrl_channel: one memory channel FSM with registered memory-side requests
// Write path and WRITE_WAIT exist only when MEMCTRL_WRITE_EN is defined.
module mem_ctrl_channel
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int IDX_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 grant,
  input  logic                 grant_write,
  input  logic [IDX_BITS-1:0]  grant_idx,
  input  logic [ADDR_BITS-1:0] grant_address,
  input  logic [DATA_BITS-1:0] grant_data,
  input  logic                 owner_valid,
  output logic                 busy,
  output logic [IDX_BITS-1:0]  owner,
  output logic                 read_done,
  output logic                 write_done,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready
);
  channel_state_t state, state_next;
  logic take, is_write;
  assign busy = state != IDLE;
  assign take = state == IDLE && grant;
`ifdef MEMCTRL_WRITE_EN
  assign is_write = grant_write;
`else
  assign is_write = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    read_done = 1'b0;
    write_done = 1'b0;
    case (state)
      IDLE: state_next = grant ? (is_write ? WRITE_WAIT : READ_WAIT) : IDLE;
      READ_WAIT: begin
        read_done = mem_read_ready;
        state_next = mem_read_ready ? RELEASE : READ_WAIT;
      end
`ifdef MEMCTRL_WRITE_EN
      WRITE_WAIT: begin
        write_done = mem_write_ready;
        state_next = mem_write_ready ? RELEASE : WRITE_WAIT;
      end
`endif
      RELEASE: state_next = owner_valid ? RELEASE : IDLE;
      default: state_next = IDLE;
    endcase
  end
  // Valid follows the next state so it rises on grant and falls on the ready edge.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner <= '0;
      mem_read_valid <= 1'b0;
      mem_read_address <= '0;
    end else begin
      owner <= take ? grant_idx : owner;
      mem_read_valid <= state_next == READ_WAIT;
      mem_read_address <= take && !is_write ? grant_address : mem_read_address;
    end
`ifdef MEMCTRL_WRITE_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_write_valid <= 1'b0;
      mem_write_address <= '0;
      mem_write_data <= '0;
    end else begin
      mem_write_valid <= state_next == WRITE_WAIT;
      mem_write_address <= take && is_write ? grant_address : mem_write_address;
      mem_write_data <= take && is_write ? grant_data : mem_write_data;
    end
`else
  logic unused_write;
  assign unused_write = ^{grant_write, grant_data, mem_write_ready};
  assign mem_write_valid = 1'b0;
  assign mem_write_address = '0;
  assign mem_write_data = '0;
`endif
endmodule

// File: rtl/data_mem_controller.sv
// data_mem_controller: round-robin arbitration of per-thread memory requests onto NUM_CHANNELS channels
// Define MEMCTRL_WRITE_EN for the data-memory build; leave undefined for the read-only program-memory build.
module data_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);
  localparam int IW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
  logic [IW-1:0] rr, last_idx;
  logic any_grant;
  logic [NUM_CONSUMERS-1:0] write_req, pending, taken;
  logic [NUM_CONSUMERS-1:0][IW-1:0] cand;
  logic [NUM_CHANNELS-1:0] busy, grant, grant_write, owner_valid, read_done, write_done;
  logic [NUM_CHANNELS-1:0][IW-1:0] owner, grant_idx;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] grant_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] grant_data;
`ifdef MEMCTRL_WRITE_EN
  assign write_req = consumer_write_valid;
`else
  assign write_req = '0;
  logic unused_write;
  assign unused_write = ^{consumer_write_valid, write_done};
`endif
  assign pending = consumer_read_valid | write_req;
  for (genvar k = 0; k < NUM_CONSUMERS; k++) begin : g_cand
    assign cand[k] = IW'(wrap_add(int'(rr), k, NUM_CONSUMERS));
  end
  // Consumers held by any non-idle channel (including RELEASE) are off limits.
  always_comb begin
    taken = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (busy[c]) taken[owner[c]] = 1'b1;
    grant = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    last_idx = rr;
    for (int c = 0; c < NUM_CHANNELS; c++)
      for (int k = 0; k < NUM_CONSUMERS; k++)
        if (!busy[c] && !grant[c] && pending[cand[k]] && !taken[cand[k]]) begin
          grant[c] = 1'b1;
          grant_idx[c] = cand[k];
          taken[cand[k]] = 1'b1;
          any_grant = 1'b1;
          last_idx = cand[k];
        end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) rr <= '0;
    else rr <= any_grant ? IW'(wrap_add(int'(last_idx), 1, NUM_CONSUMERS)) : rr;
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign grant_write[i] = ~consumer_read_valid[grant_idx[i]];
    assign grant_address[i] = grant_write[i] ? consumer_write_address[grant_idx[i]] : consumer_read_address[grant_idx[i]];
    assign grant_data[i] = consumer_write_data[grant_idx[i]];
    assign owner_valid[i] = consumer_read_valid[owner[i]] | write_req[owner[i]];
    mem_ctrl_channel #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .IDX_BITS(IW)) u_channel (
      .clk(clk),
      .reset(reset),
      .grant(grant[i]),
      .grant_write(grant_write[i]),
      .grant_idx(grant_idx[i]),
      .grant_address(grant_address[i]),
      .grant_data(grant_data[i]),
      .owner_valid(owner_valid[i]),
      .busy(busy[i]),
      .owner(owner[i]),
      .read_done(read_done[i]),
      .write_done(write_done[i]),
      .mem_read_valid(mem_read_valid[i]),
      .mem_read_address(mem_read_address[i]),
      .mem_read_ready(mem_read_ready[i]),
      .mem_write_valid(mem_write_valid[i]),
      .mem_write_address(mem_write_address[i]),
      .mem_write_data(mem_write_data[i]),
      .mem_write_ready(mem_write_ready[i])
    );
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      consumer_read_ready <= '0;
      consumer_read_data <= '0;
    end else begin
      consumer_read_ready <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (read_done[c]) begin
          consumer_read_ready[owner[c]] <= 1'b1;
          consumer_read_data[owner[c]] <= mem_read_data[c];
        end
    end
`ifdef MEMCTRL_WRITE_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) consumer_write_ready <= '0;
    else begin
      consumer_write_ready <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (write_done[c]) consumer_write_ready[owner[c]] <= 1'b1;
    end
`else
  assign consumer_write_ready = '0;
`endif
endmodule
